// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph codes, segment
// bit order and a width helper for the counters.
package seg_pkg;

  localparam int GLYPH_CODE_W = 5;
  localparam int SEG_W        = 7;

  // Segment bit positions within seg_out; a is the MSB, g the LSB.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_t;

  localparam logic [GLYPH_CODE_W-1:0] CODE_L     = 5'd16;
  localparam logic [GLYPH_CODE_W-1:0] CODE_DASH  = 5'd17;
  localparam logic [GLYPH_CODE_W-1:0] CODE_BLANK = 5'd18;
  localparam logic [GLYPH_CODE_W-1:0] CODE_P     = 5'd19;
  localparam logic [GLYPH_CODE_W-1:0] CODE_N     = 5'd20;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Glyph code to active-low segment pattern {a..g}; unlisted codes are blank.
module seg_glyph_rom
  import seg_pkg::*;
#(
  parameter int CODE_W = GLYPH_CODE_W
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg
);

  logic [31:0] w_code;

  assign w_code = 32'(i_code);

  always_comb begin
    o_seg = SEG_BLANK;
    case (w_code)
      32'd0:  o_seg = 7'b0000001;
      32'd1:  o_seg = 7'b1001111;
      32'd2:  o_seg = 7'b0010010;
      32'd3:  o_seg = 7'b0000110;
      32'd4:  o_seg = 7'b1001100;
      32'd5:  o_seg = 7'b0100100;
      32'd6:  o_seg = 7'b0100000;
      32'd7:  o_seg = 7'b0001111;
      32'd8:  o_seg = 7'b0000000;
      32'd9:  o_seg = 7'b0000100;
      32'd10: o_seg = 7'b0001000;
      32'd11: o_seg = 7'b1100000;
      32'd12: o_seg = 7'b0110001;
      32'd13: o_seg = 7'b1000010;
      32'd14: o_seg = 7'b0110000;
      32'd15: o_seg = 7'b0111000;
      32'd16: o_seg = 7'b1110001;
      32'd17: o_seg = 7'b1111110;
      32'd18: o_seg = SEG_BLANK;
      32'd19: o_seg = 7'b0011000;
      32'd20: o_seg = 7'b1101010;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned
// glyph commit, per-slot dead time, blink and decimal-point control.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CODE_W       = 5,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_DIGITS*CODE_W-1:0] codes_in,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic                         load,
  output logic [SEG_W-1:0]             seg_out,
  output logic                         dp_out,
  output logic [NUM_DIGITS-1:0]        an_out,
  output logic                         frame_done
);

  localparam int CNT_W = clog2_min1(REFRESH_DIV);
  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int FRM_W = clog2_min1(BLINK_FRAMES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  localparam logic [NUM_DIGITS*CODE_W-1:0] SHADOW_BLANK = {NUM_DIGITS{CODE_W'(CODE_BLANK)}};

  // Scan position
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_slot_end;
  logic             w_frame_end;

  // Pending (written by load) and shadow (displayed) registers
  logic [NUM_DIGITS*CODE_W-1:0] r_pend_codes;
  logic [NUM_DIGITS-1:0]        r_pend_dp;
  logic [NUM_DIGITS-1:0]        r_pend_blink;
  logic                         r_pend_valid;
  logic [NUM_DIGITS*CODE_W-1:0] r_sh_codes;
  logic [NUM_DIGITS-1:0]        r_sh_dp;
  logic [NUM_DIGITS-1:0]        r_sh_blink;

  // Blink timing
  logic [FRM_W-1:0] r_frame_cnt;
  logic             r_blink_phase;

  // Registered outputs
  logic [SEG_W-1:0]      r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  // Current digit selection
  logic [CODE_W-1:0]     w_sh_code_arr [NUM_DIGITS];
  logic [CODE_W-1:0]     w_cur_code;
  logic                  w_cur_dp;
  logic                  w_cur_blink;
  logic [SEG_W-1:0]      w_glyph;
  logic                  w_an_on;
  logic                  w_blanked;
  logic [NUM_DIGITS-1:0] w_an_sel;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load landing on the frame-end edge bypasses pending so it shows next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_codes <= SHADOW_BLANK;
      r_pend_dp    <= '0;
      r_pend_blink <= '0;
      r_pend_valid <= 1'b0;
      r_sh_codes   <= SHADOW_BLANK;
      r_sh_dp      <= '0;
      r_sh_blink   <= '0;
    end else if (load && w_frame_end) begin
      r_sh_codes   <= codes_in;
      r_sh_dp      <= dp_in;
      r_sh_blink   <= blink_mask;
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pend_codes <= codes_in;
      r_pend_dp    <= dp_in;
      r_pend_blink <= blink_mask;
      r_pend_valid <= 1'b1;
    end else if (w_frame_end && r_pend_valid) begin
      r_sh_codes   <= r_pend_codes;
      r_sh_dp      <= r_pend_dp;
      r_sh_blink   <= r_pend_blink;
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRM_LAST) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
    assign w_sh_code_arr[gi] = r_sh_codes[gi*CODE_W +: CODE_W];
  end

  assign w_cur_code  = w_sh_code_arr[r_idx];
  assign w_cur_dp    = r_sh_dp[r_idx];
  assign w_cur_blink = r_sh_blink[r_idx];

  seg_glyph_rom #(
    .CODE_W (CODE_W)
  ) u_glyph_rom (
    .i_code (w_cur_code),
    .o_seg  (w_glyph)
  );

  assign w_an_on   = (r_cnt >= CNT_DEAD);
  assign w_blanked = r_blink_phase && w_cur_blink;
  assign w_an_sel  = ~(NUM_DIGITS'(1) << r_idx);

  // Blinked digits keep their anode so the duty cycle stays constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_an_on) begin
        r_an <= w_an_sel;
        if (w_blanked) begin
          r_seg <= SEG_BLANK;
          r_dp  <= 1'b1;
        end else begin
          r_seg <= w_glyph;
          r_dp  <= ~w_cur_dp;
        end
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign an_out     = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a short refresh period.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int CW    = 5;
  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * RD;

  logic             clk = 1'b0;
  logic             reset;
  logic [ND*CW-1:0] codes_in;
  logic [ND-1:0]    dp_in;
  logic [ND-1:0]    blink_mask;
  logic             load;
  logic [6:0]       seg_out;
  logic             dp_out;
  logic [ND-1:0]    an_out;
  logic             frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .CODE_W       (CW),
    .REFRESH_DIV  (RD),
    .DEAD_CYCLES  (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .codes_in   (codes_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .load       (load),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walks one full frame from its first edge, optionally pulsing load at slot ld_pos.
  task automatic check_frame(input string tag, input logic [3:0][6:0] exp_seg,
                             input logic [3:0] exp_dp, input int ld_pos,
                             input logic [ND*CW-1:0] ld_codes, input logic [ND-1:0] ld_dp,
                             input logic [ND-1:0] ld_blink);
    for (int j = 0; j < FRAME; j++) begin
      int d;
      int c;
      logic [ND-1:0] e_an;
      logic [6:0]    e_seg;
      logic          e_dp;
      d = j / RD;
      c = j % RD;
      if (j == ld_pos) begin
        codes_in   = ld_codes;
        dp_in      = ld_dp;
        blink_mask = ld_blink;
        load       = 1'b1;
      end
      tick();
      load = 1'b0;
      if (c >= DC) begin
        e_an  = ~(ND'(1) << d);
        e_seg = exp_seg[d];
        e_dp  = exp_dp[d];
      end else begin
        e_an  = '1;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      chk_val($sformatf("%s j%0d an", tag, j), 32'(an_out), 32'(e_an));
      chk_val($sformatf("%s j%0d seg", tag, j), 32'(seg_out), 32'(e_seg));
      chk_val($sformatf("%s j%0d dp", tag, j), 32'(dp_out), 32'(e_dp));
      chk_val($sformatf("%s j%0d fd", tag, j), 32'(frame_done), 32'(j == FRAME - 1));
    end
  endtask

  initial begin
    logic [ND-1:0] e_an;
    bit            got_fd;

    reset      = 1'b1;
    codes_in   = '0;
    dp_in      = '0;
    blink_mask = '0;
    load       = 1'b0;
    repeat (3) tick();
    chk_val("rst seg", 32'(seg_out), 32'h7F);
    chk_val("rst dp", 32'(dp_out), 32'h1);
    chk_val("rst an", 32'(an_out), 32'hF);
    chk_val("rst fd", 32'(frame_done), 32'h0);

    // Idle scan with a blank shadow
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      e_an = ((k % RD) >= DC) ? ~(ND'(1) << ((k / RD) % ND)) : '1;
      chk_val($sformatf("idle k%0d an", k), 32'(an_out), 32'(e_an));
      chk_val($sformatf("idle k%0d seg", k), 32'(seg_out), 32'h7F);
      chk_val($sformatf("idle k%0d fd", k), 32'(frame_done), 32'((k % FRAME) == FRAME - 1));
    end

    // Mid-frame load must not show until the frame boundary
    codes_in = {5'd3, 5'd2, 5'd1, 5'd0};
    load     = 1'b1;
    tick();
    load = 1'b0;
    chk_val("midload seg", 32'(seg_out), 32'h7F);
    got_fd = 1'b0;
    for (int w = 0; w < 40 && !got_fd; w++) begin
      tick();
      chk_val($sformatf("midload w%0d seg", w), 32'(seg_out), 32'h7F);
      if (frame_done) got_fd = 1'b1;
    end
    if (!got_fd) chk_val("frame sync timeout", 32'(got_fd), 32'h1);

    check_frame("f2_0123", {7'h06, 7'h12, 7'h4F, 7'h01}, 4'hF,
                FRAME - 1, {5'd17, 5'd20, 5'd19, 5'd16}, 4'h0, 4'h0);
    check_frame("f3_LPnd", {7'h7E, 7'h6A, 7'h18, 7'h71}, 4'hF, -1, '0, '0, '0);
    check_frame("f4_LPnd", {7'h7E, 7'h6A, 7'h18, 7'h71}, 4'hF,
                10, {4{5'd8}}, 4'b0001, 4'b0010);
    check_frame("f5_blk_on", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1110, -1, '0, '0, '0);
    check_frame("f6_blk_off", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b1110, -1, '0, '0, '0);
    check_frame("f7_blk_off", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b1110, -1, '0, '0, '0);
    check_frame("f8_blk_on", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1110,
                5, {5'd0, 5'd25, 5'd0, 5'd0}, 4'h0, 4'h0);
    check_frame("f9_code25", {7'h01, 7'h7F, 7'h01, 7'h01}, 4'hF, -1, '0, '0, '0);

    // Reset in the middle of digit 2's slot
    repeat (20) tick();
    chk_val("pre-rst an", 32'(an_out), 32'hB);
    chk_val("pre-rst seg", 32'(seg_out), 32'h7F);
    reset = 1'b1;
    tick();
    chk_val("midrst seg", 32'(seg_out), 32'h7F);
    chk_val("midrst dp", 32'(dp_out), 32'h1);
    chk_val("midrst an", 32'(an_out), 32'hF);
    chk_val("midrst fd", 32'(frame_done), 32'h0);
    reset = 1'b0;
    tick();
    chk_val("post-rst k0 an", 32'(an_out), 32'hF);
    tick();
    chk_val("post-rst k1 an", 32'(an_out), 32'hF);
    tick();
    chk_val("post-rst k2 an", 32'(an_out), 32'hE);
    chk_val("post-rst k2 seg", 32'(seg_out), 32'h7F);
    chk_val("post-rst k2 dp", 32'(dp_out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
